// File: rtl/pointer_mapper_if.sv
// Signal bundle between the spot tracker / calibration logic and pointer_mapper.
// The master drives bounds and points; the slave (pointer_mapper) returns mapped results.
interface pointer_mapper_if;
  logic        cal_done;
  logic [10:0] xo;
  logic [10:0] xf;
  logic [10:0] yo;
  logic [10:0] yf;
  logic        pt_valid;
  logic [10:0] pt_x;
  logic [10:0] pt_y;
  logic        pt_ready;
  logic        out_valid;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        out_err;

  modport master (
    output cal_done, xo, xf, yo, yf, pt_valid, pt_x, pt_y,
    input  pt_ready, out_valid, sx, sy, out_err
  );

  modport slave (
    input  cal_done, xo, xf, yo, yf, pt_valid, pt_x, pt_y,
    output pt_ready, out_valid, sx, sy, out_err
  );
endinterface

// File: rtl/pointer_mapper.sv
// Maps camera-space points into screen coordinates using the calibration rectangle,
// one shared serial restoring divider per conversion. Define MIRROR_X_EN for a mirrored camera.
module pointer_mapper #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int DIV_BITS = 22
) (
  input logic             clk,
  input logic             reset,
  pointer_mapper_if.slave bus
);

  localparam int                CNT_W   = $clog2(DIV_BITS);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DIV_BITS - 1);
  localparam logic [9:0]        SX_MAX  = 10'(SCREEN_W - 1);
  localparam logic [DIV_BITS-1:0] SCALE_X = DIV_BITS'(SCREEN_W - 1);
  localparam logic [DIV_BITS-1:0] SCALE_Y = DIV_BITS'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, CALC_X, DIV_X, CALC_Y, DIV_Y, DONE} state_t;

  state_t              state, state_next;
  logic                run;
  logic                accept;

  logic [10:0]         px, py, xo_c, xf_c, yo_c, yf_c;
  logic [CNT_W-1:0]    cnt;
  logic [DIV_BITS-1:0] quo, quo_next;
  logic [10:0]         rem, rem_next, divisor;
  logic [11:0]         trial;
  logic [9:0]          qx, sx_map;
  logic                err_x, err_y;
  logic [9:0]          sx_q, sy_q;
  logic                err_q;

  logic [10:0]         c_p, c_lo, c_hi, span, off;
  logic [DIV_BITS-1:0] scale, dividend;
  logic                c_degen;

  // run holds pt_ready low through the first cycle after reset is released.
  assign bus.pt_ready  = run && (state == IDLE) && bus.cal_done;
  assign accept        = bus.pt_valid && bus.pt_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.sx        = sx_q;
  assign bus.sy        = sy_q;
  assign bus.out_err   = err_q;

  // Operand setup for whichever axis is being prepared.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    c_p   = px;
    c_lo  = xo_c;
    c_hi  = xf_c;
    scale = SCALE_X;
    if (state == CALC_Y) begin
      c_p   = py;
      c_lo  = yo_c;
      c_hi  = yf_c;
      scale = SCALE_Y;
    end
    c_degen = (c_hi <= c_lo);
    span    = c_hi - c_lo;
    if (c_p < c_lo)      off = '0;
    else if (c_p > c_hi) off = span;
    else                 off = c_p - c_lo;
    dividend = DIV_BITS'(off) * scale;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem, quo[DIV_BITS-1]};
    rem_next = trial[10:0];
    quo_next = {quo[DIV_BITS-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      rem_next = 11'(trial - {1'b0, divisor});
      quo_next = {quo[DIV_BITS-2:0], 1'b1};
    end
  end

`ifdef MIRROR_X_EN
  assign sx_map = SX_MAX - qx;
`else
  assign sx_map = qx;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = CALC_X;
      CALC_X:  state_next = DIV_X;
      DIV_X:   if (cnt == LAST) state_next = CALC_Y;
      CALC_Y:  state_next = DIV_Y;
      DIV_Y:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= IDLE;
      run   <= 1'b0;
      sx_q  <= '0;
      sy_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      run   <= 1'b1;
      // Results land on the edge into DONE so they are valid alongside out_valid.
      if (state == DIV_Y && cnt == LAST) begin
        sx_q  <= err_x ? '0 : sx_map;
        sy_q  <= err_y ? '0 : quo_next[9:0];
        err_q <= err_x | err_y;
      end
    end
  end

  // NOTE: datapath registers carry no reset; each is loaded before the FSM ever reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      px   <= bus.pt_x;
      py   <= bus.pt_y;
      xo_c <= bus.xo;
      xf_c <= bus.xf;
      yo_c <= bus.yo;
      yf_c <= bus.yf;
    end
    unique case (state)
      CALC_X, CALC_Y: begin
        // A degenerate axis still runs the full divide, against 1, to keep latency fixed.
        quo     <= c_degen ? '0 : dividend;
        rem     <= '0;
        divisor <= c_degen ? 11'd1 : span;
        cnt     <= '0;
        if (state == CALC_X) err_x <= c_degen;
        else                 err_y <= c_degen;
      end
      DIV_X, DIV_Y: begin
        quo <= quo_next;
        rem <= rem_next;
        cnt <= cnt + CNT_W'(1);
        if (state == DIV_X && cnt == LAST) qx <= quo_next[9:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pointer_mapper.sv
// Randomized self-checking bench for pointer_mapper against an arithmetic reference model.
// Honours MIRROR_X_EN the same way the design does.
module tb_pointer_mapper;
  localparam int LAT    = 46;
  localparam int PERIOD = 48;

  typedef struct {
    int cyc;
    int sx;
    int sy;
    int err;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   bxo, bxf, byo, byf;

  int   acc_q[$];
  out_t out_q[$];

  pointer_mapper_if bus ();

  pointer_mapper dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accept edge is the posedge after the negedge where the handshake is seen.
  always @(negedge clk) begin
    if (bus.pt_valid && bus.pt_ready) acc_q.push_back(cyc + 1);
    if (bus.out_valid) out_q.push_back('{cyc, int'(bus.sx), int'(bus.sy), int'(bus.out_err)});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_axis(int p, int lo, int hi, int full);
    int off;
    if (hi <= lo) return 0;
    if (p < lo)      off = 0;
    else if (p > hi) off = hi - lo;
    else             off = p - lo;
    return (off * (full - 1)) / (hi - lo);
  endfunction

  function automatic int ref_sx(int p);
    int q;
    q = ref_axis(p, bxo, bxf, 1024);
`ifdef MIRROR_X_EN
    if (bxf > bxo) q = 1023 - q;
`endif
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bounds(input int a, input int b, input int c, input int d);
    bxo = a; bxf = b; byo = c; byf = d;
    bus.xo = 11'(a); bus.xf = 11'(b); bus.yo = 11'(c); bus.yf = 11'(d);
  endtask

  task automatic wait_accepts(input int want, input string tag);
    int n = 0;
    while (acc_q.size() < want && n < 200) begin tick(); n++; end
    if (acc_q.size() < want) check({tag, "_accept_timeout"}, acc_q.size(), want);
  endtask

  task automatic wait_outs(input int want, input string tag);
    int n = 0;
    while (out_q.size() < want && n < 200) begin tick(); n++; end
    if (out_q.size() < want) check({tag, "_out_timeout"}, out_q.size(), want);
  endtask

  // One conversion; disturb scrambles inputs, drops cal_done and pulses pt_valid mid-flight.
  task automatic run_one(input int px, input int py, input string tag, input bit disturb);
    int esx, esy, eerr;
    esx  = ref_sx(px);
    esy  = ref_axis(py, byo, byf, 768);
    eerr = ((bxf <= bxo) || (byf <= byo)) ? 1 : 0;
    acc_q.delete();
    out_q.delete();
    tick();
    bus.pt_x = 11'(px);
    bus.pt_y = 11'(py);
    bus.pt_valid = 1'b1;
    wait_accepts(1, tag);
    bus.pt_valid = 1'b0;
    if (acc_q.size() == 0) return;
    if (disturb) begin
      bus.xo = 11'($urandom_range(0, 2047));
      bus.yf = 11'($urandom_range(0, 2047));
      bus.pt_x = 11'($urandom_range(0, 2047));
      bus.cal_done = 1'b0;
      repeat (5) tick();
      bus.cal_done = 1'b1;
      bus.pt_valid = 1'b1;
      repeat (3) tick();
      bus.pt_valid = 1'b0;
    end
    wait_outs(1, tag);
    if (out_q.size() == 0) return;
    check({tag, "_latency"}, out_q[0].cyc - acc_q[0], LAT);
    check({tag, "_sx"}, out_q[0].sx, esx);
    check({tag, "_sy"}, out_q[0].sy, esy);
    check({tag, "_err"}, out_q[0].err, eerr);
    check({tag, "_accepts"}, acc_q.size(), 1);
    check({tag, "_pulse_len"}, bus.out_valid, 0);
    check({tag, "_sx_hold"}, bus.sx, esx);
    set_bounds(bxo, bxf, byo, byf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.cal_done = 1'b1;
    bus.pt_valid = 1'b0;
    bus.pt_x = '0;
    bus.pt_y = '0;
    set_bounds(100, 600, 100, 500);
    repeat (3) tick();
    @(negedge clk);
    check("rst_pt_ready", bus.pt_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sx", bus.sx, 0);
    check("rst_sy", bus.sy, 0);
    check("rst_err", bus.out_err, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    check("ready_after_rst", bus.pt_ready, 1);

    run_one(350, 300, "nominal", 1'b0);
    run_one(50, 700, "clamp_lo_hi", 1'b0);
    run_one(600, 100, "clamp_edge", 1'b0);
    run_one(700, 50, "clamp_hi_lo", 1'b0);

    set_bounds(200, 200, 100, 500);
    run_one(200, 300, "degen_x", 1'b0);
    set_bounds(100, 600, 450, 300);
    run_one(350, 400, "degen_y", 1'b0);

    set_bounds(100, 600, 100, 500);
    run_one(420, 260, "disturb", 1'b1);

    // Continuous pt_valid: accepts must be one conversion period apart.
    acc_q.delete();
    out_q.delete();
    tick();
    bus.pt_x = 11'(350);
    bus.pt_y = 11'(300);
    bus.pt_valid = 1'b1;
    wait_accepts(2, "held");
    bus.pt_valid = 1'b0;
    if (acc_q.size() >= 2) check("held_spacing", acc_q[1] - acc_q[0], PERIOD);
    wait_outs(2, "held");

    // cal_done low blocks accepts entirely.
    repeat (3) tick();
    acc_q.delete();
    bus.cal_done = 1'b0;
    bus.pt_valid = 1'b1;
    repeat (10) tick();
    check("nocal_pt_ready", bus.pt_ready, 0);
    check("nocal_accepts", acc_q.size(), 0);
    bus.pt_valid = 1'b0;
    bus.cal_done = 1'b1;

    for (int i = 0; i < 20; i++) begin
      int a, b, c, d;
      a = $urandom_range(0, 1500);
      b = ($urandom_range(0, 4) == 0) ? $urandom_range(0, a) : a + $urandom_range(1, 547);
      c = $urandom_range(0, 1500);
      d = ($urandom_range(0, 4) == 0) ? $urandom_range(0, c) : c + $urandom_range(1, 547);
      set_bounds(a, b, c, d);
      run_one($urandom_range(0, 2047), $urandom_range(0, 2047), $sformatf("rand%0d", i), 1'b0);
    end

    // Reset during DIV_Y aborts the conversion and clears the outputs.
    set_bounds(100, 600, 100, 500);
    run_one(350, 300, "pre_reset", 1'b0);
    acc_q.delete();
    out_q.delete();
    bus.pt_x = 11'(700);
    bus.pt_y = 11'(50);
    bus.pt_valid = 1'b1;
    wait_accepts(1, "abort");
    bus.pt_valid = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (60) tick();
    check("abort_no_out", out_q.size(), 0);
    check("abort_sx", bus.sx, 0);
    check("abort_sy", bus.sy, 0);
    check("abort_err", bus.out_err, 0);
    run_one(350, 300, "post_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
